// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared FSM encoding, default parameters and width helper for fc_ctrl
package fc_pkg;

    localparam int CLASS_NUM_DEF  = 30;
    localparam int W_WL_DEF       = 1;
    localparam int INPUT_SIZE_DEF = 162;
    localparam int D_WL_DEF       = 16;
    localparam int WAIT_MAX_DEF   = 1024;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DRAIN  = 3'd2,
        S_WAIT   = 3'd3,
        S_ARGMAX = 3'd4,
        S_OUT    = 3'd5
    } fc_state_e;

    // Bits needed to index v distinct values (AW = clog2(INPUT_SIZE), CW = clog2(CLASS_NUM)).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fc_argmax.sv
// rtl/fc_argmax.sv - sequential argmax, one class per cycle, ties keep the lowest index
module fc_argmax
    import fc_pkg::*;
#(
    parameter int CLASS_NUM = CLASS_NUM_DEF,
    parameter int D_WL      = D_WL_DEF,
    parameter int CW        = clog2(CLASS_NUM_DEF)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [CLASS_NUM*D_WL-1:0] scores,
    output logic                      done,
    output logic [CW-1:0]             max_idx
);

    logic signed [D_WL-1:0] sc [CLASS_NUM];

    // Class j lives in slice CLASS_NUM-1-j, so class 0 is the top slice.
    for (genvar k = 0; k < CLASS_NUM; k++) begin : g_unpack
        assign sc[k] = scores[(CLASS_NUM-1-k)*D_WL +: D_WL];
    end

    logic                   run_q,  run_d;
    logic [CW-1:0]          j_q,    j_d;
    logic [CW-1:0]          idx_q,  idx_d;
    logic signed [D_WL-1:0] best_q, best_d;

    always_comb begin
        run_d  = run_q;
        j_d    = j_q;
        idx_d  = idx_q;
        best_d = best_q;
        done   = 1'b0;
        if (start) begin
            run_d  = 1'b1;
            j_d    = '0;
            idx_d  = '0;
            best_d = {1'b1, {(D_WL-1){1'b0}}};
        end else if (run_q) begin
            // Seeded with the most negative value so an all-minimum vector still yields class 0.
            if (sc[j_q] > best_q) begin
                best_d = sc[j_q];
                idx_d  = j_q;
            end
            if (j_q == CW'(CLASS_NUM - 1)) begin
                run_d = 1'b0;
                done  = 1'b1;
            end else begin
                j_d = j_q + CW'(1);
            end
        end
        max_idx = idx_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q  <= 1'b0;
            j_q    <= '0;
            idx_q  <= '0;
            best_q <= '0;
        end else begin
            run_q  <= run_d;
            j_q    <= j_d;
            idx_q  <= idx_d;
            best_q <= best_d;
        end
    end

endmodule

// File: rtl/fc_ctrl.sv
// rtl/fc_ctrl.sv - fully-connected layer sequencer: stream operands, await array result, argmax
module fc_ctrl
    import fc_pkg::*;
#(
    parameter int CLASS_NUM  = CLASS_NUM_DEF,
    parameter int W_WL       = W_WL_DEF,
    parameter int INPUT_SIZE = INPUT_SIZE_DEF,
    parameter int D_WL       = D_WL_DEF,
    parameter int WAIT_MAX   = WAIT_MAX_DEF,
    localparam int AW        = clog2(INPUT_SIZE),
    localparam int CW        = clog2(CLASS_NUM)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      fm_rd_en,
    output logic [AW-1:0]             fm_addr,
    input  logic [D_WL-1:0]           fm_rdata,
    output logic                      w_rd_en,
    output logic [AW-1:0]             w_addr,
    input  logic [CLASS_NUM*W_WL-1:0] w_rdata,
    output logic                      fc_in_valid,
    output logic [D_WL-1:0]           fc_x,
    output logic [CLASS_NUM*W_WL-1:0] fc_w,
    input  logic                      fc_o_valid,
    input  logic [CLASS_NUM*D_WL-1:0] fc_o,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [CLASS_NUM*D_WL-1:0] res_data,
    output logic [CW-1:0]             res_class,
    output logic                      err
);

    localparam int WTW = clog2(WAIT_MAX + 1);

    fc_state_e                 state_q,       state_d;
    logic                      busy_q,        busy_d;
    logic                      fm_rd_en_q,    fm_rd_en_d;
    logic [AW-1:0]             fm_addr_q,     fm_addr_d;
    logic                      fc_in_valid_q, fc_in_valid_d;
    logic [WTW-1:0]            wait_cnt_q,    wait_cnt_d;
    logic                      err_q,         err_d;
    logic                      res_valid_q,   res_valid_d;
    logic [CLASS_NUM*D_WL-1:0] res_data_q,    res_data_d;
    logic [CW-1:0]             res_class_q,   res_class_d;

    logic          am_start;
    logic          am_done;
    logic [CW-1:0] am_class;

    fc_argmax #(
        .CLASS_NUM (CLASS_NUM),
        .D_WL      (D_WL),
        .CW        (CW)
    ) u_argmax (
        .clk     (clk),
        .rst     (rst),
        .start   (am_start),
        .scores  (res_data_q),
        .done    (am_done),
        .max_idx (am_class)
    );

    always_comb begin
        state_d     = state_q;
        fm_rd_en_d  = 1'b0;
        fm_addr_d   = fm_addr_q;
        wait_cnt_d  = wait_cnt_q;
        err_d       = 1'b0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_class_d = res_class_q;
        am_start    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    fm_rd_en_d = 1'b1;
                    fm_addr_d  = '0;
                end
            end
            S_FETCH: begin
                if (fm_addr_q == AW'(INPUT_SIZE - 1)) begin
                    state_d   = S_DRAIN;
                    fm_addr_d = '0;
                end else begin
                    fm_rd_en_d = 1'b1;
                    fm_addr_d  = fm_addr_q + AW'(1);
                end
            end
            S_DRAIN: begin
                state_d    = S_WAIT;
                wait_cnt_d = '0;
            end
            S_WAIT: begin
                // A result arriving on the final budgeted cycle still wins over the timeout.
                if (fc_o_valid) begin
                    res_data_d = fc_o;
                    am_start   = 1'b1;
                    state_d    = S_ARGMAX;
                end else if (wait_cnt_q == WTW'(WAIT_MAX - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WTW'(1);
                end
            end
            S_ARGMAX: begin
                if (am_done) begin
                    res_class_d = am_class;
                    res_valid_d = 1'b1;
                    state_d     = S_OUT;
                end
            end
            S_OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d        = (state_d != S_IDLE);
        fc_in_valid_d = fm_rd_en_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            fm_rd_en_q    <= 1'b0;
            fm_addr_q     <= '0;
            fc_in_valid_q <= 1'b0;
            wait_cnt_q    <= '0;
            err_q         <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_class_q   <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            fm_rd_en_q    <= fm_rd_en_d;
            fm_addr_q     <= fm_addr_d;
            fc_in_valid_q <= fc_in_valid_d;
            wait_cnt_q    <= wait_cnt_d;
            err_q         <= err_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_class_q   <= res_class_d;
        end
    end

    // Both memories share one address counter so their read streams stay aligned.
    assign busy        = busy_q;
    assign fm_rd_en    = fm_rd_en_q;
    assign fm_addr     = fm_addr_q;
    assign w_rd_en     = fm_rd_en_q;
    assign w_addr      = fm_addr_q;
    assign fc_in_valid = fc_in_valid_q;
    assign fc_x        = fm_rdata;
    assign fc_w        = w_rdata;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_class   = res_class_q;
    assign err         = err_q;

endmodule
